// File: rtl/pipelined_array_divider.sv
// Unsigned restoring array divider with a fixed-latency pipeline.
// The quotient is resolved MSB-first, QUOTIENT_PER_STAGE bits per
// combinational stage. A register sits between consecutive stages, so the
// result of an accepted operation appears PIPELINE_DEPTH-1 enabled edges later.
// Handshake: data_valid_i qualifies the operands on a cycle with clk_en_i=1.
// data_valid_o qualifies the outputs. There is no backpressure, and results
// leave in issue order.
module pipelined_array_divider #(
   parameter int DATA_WIDTH     = 16,
   parameter int PIPELINE_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  clk_en_i,
   input  logic [DATA_WIDTH-1:0] dividend_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   input  logic                  data_valid_i,
   output logic [DATA_WIDTH-1:0] quotient_o,
   output logic [DATA_WIDTH-1:0] remainder_o,
   output logic                  divide_by_zero_o,
   output logic                  data_valid_o
);

   localparam int QUOTIENT_PER_STAGE = DATA_WIDTH / PIPELINE_DEPTH;
   localparam int REM_WIDTH          = DATA_WIDTH + 1;
   localparam int NUM_REGS           = PIPELINE_DEPTH - 1;

   // Everything one stage hands to the next.
   // dvd holds the dividend bits that have not been consumed yet, left-aligned.
   typedef struct packed {
      logic [REM_WIDTH-1:0]  rem;
      logic [DATA_WIDTH-1:0] dvd;
      logic [DATA_WIDTH-1:0] dsr;
      logic [DATA_WIDTH-1:0] quo;
      logic                  dz;
   } stage_t;

   // One stage of the restoring algorithm: QUOTIENT_PER_STAGE shift/trial-subtract steps.
   // rem is always below max(divisor, 2^DATA_WIDTH). Because of that, the top bit
   // of the DATA_WIDTH+1 bit difference is exactly the borrow. With divisor 0, a
   // borrow never occurs, so the quotient becomes all ones and the remainder
   // collects the dividend.
   function automatic stage_t f_divide_stage(input stage_t s);
      stage_t               t;
      logic [REM_WIDTH-1:0] sh;
      logic [REM_WIDTH-1:0] diff;
      logic                 borrow;
      t = s;
      for (int i = 0; i < QUOTIENT_PER_STAGE; i++) begin
         sh     = {t.rem[REM_WIDTH-2:0], t.dvd[DATA_WIDTH-1]};
         t.dvd  = t.dvd << 1;
         diff   = sh - {1'b0, t.dsr};
         borrow = diff[REM_WIDTH-1];
         t.quo  = {t.quo[DATA_WIDTH-2:0], ~borrow};
         t.rem  = borrow ? sh : diff;
      end
      return t;
   endfunction

   stage_t              w_stage_in  [PIPELINE_DEPTH];
   stage_t              w_stage_out [PIPELINE_DEPTH];
   stage_t              r_pipe      [NUM_REGS];
   logic [NUM_REGS-1:0] r_valid;
   stage_t              w_last;
   logic                w_unused_final;

   assign w_stage_in[0] = '{rem: '0, dvd: dividend_i, dsr: divisor_i, quo: '0,
                            dz: (divisor_i == '0)};

   for (genvar k = 0; k < PIPELINE_DEPTH; k++) begin : g_stage
      assign w_stage_out[k] = f_divide_stage(w_stage_in[k]);
   end

   for (genvar k = 1; k < PIPELINE_DEPTH; k++) begin : g_link
      assign w_stage_in[k] = r_pipe[k-1];
   end

   // Stage registers and the valid shift chain: reset clears all, clk_en_i=0 holds all.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            r_pipe[k] <= '0;
         end
         r_valid <= '0;
      end else if (clk_en_i) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            r_pipe[k] <= w_stage_out[k];
         end
         r_valid <= (r_valid << 1) | NUM_REGS'(data_valid_i);
      end
   end

   assign w_last = w_stage_out[PIPELINE_DEPTH-1];

   // After the final stage, the remainder top bit, the consumed dividend and the
   // divisor carry no information.
   assign w_unused_final = ^{w_last.rem[DATA_WIDTH], w_last.dvd, w_last.dsr};

   // Final stage drives the outputs, gated to 0 when no valid result is present.
   always_comb begin
      quotient_o       = '0;
      remainder_o      = '0;
      divide_by_zero_o = 1'b0;
      data_valid_o     = r_valid[NUM_REGS-1];
      if (r_valid[NUM_REGS-1]) begin
         quotient_o       = w_last.quo;
         remainder_o      = w_last.rem[DATA_WIDTH-1:0];
         divide_by_zero_o = w_last.dz;
      end
   end

endmodule

// File: tb/tb_pipelined_array_divider.sv
// Self-checking bench for pipelined_array_divider (16-bit, 4 stages, latency 3).
// Directed timing tests run alongside a queue-based scoreboard. The scoreboard
// compares every emitted result against a plain-arithmetic reference model.
module tb_pipelined_array_divider;

   localparam int DW = 16;
   localparam int PD = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          clk_en;
   logic          dv_i;
   logic [DW-1:0] a_i;
   logic [DW-1:0] b_i;
   logic [DW-1:0] q_o;
   logic [DW-1:0] r_o;
   logic          dz_o;
   logic          dv_o;

   pipelined_array_divider #(.DATA_WIDTH(DW), .PIPELINE_DEPTH(PD)) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .clk_en_i         (clk_en),
      .dividend_i       (a_i),
      .divisor_i        (b_i),
      .data_valid_i     (dv_i),
      .quotient_o       (q_o),
      .remainder_o      (r_o),
      .divide_by_zero_o (dz_o),
      .data_valid_o     (dv_o)
   );

   // ---------------- scoreboard state ----------------
   int                n_checks = 0;
   int                n_pass   = 0;
   int                n_issued = 0;
   int                n_seen   = 0;
   bit                mon_on   = 1'b0;
   bit                adv      = 1'b0;
   logic [2*DW:0]     last_out = '0;
   logic [2*DW:0]     exp_q[$];
   logic [2*DW-1:0]   op_q[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Reference model: integer division, with the divide-by-zero result defined
   // as an all-ones quotient and the dividend as the remainder.
   function automatic logic [2*DW:0] ref_div(input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (b == 0) return {{DW{1'b1}}, a, 1'b1};
      return {DW'(a / b), DW'(a % b), 1'b0};
   endfunction

   // ---------------- driver ----------------
   // Applies one cycle of inputs. An operation is expected only if it is accepted
   // (en, valid, not in reset). A reset edge discards everything in flight.
   task automatic drive(input bit en, input bit v, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input bit rn);
      rst_n  = rn;
      clk_en = en;
      dv_i   = v;
      a_i    = a;
      b_i    = b;
      if (rn && en && v) begin
         exp_q.push_back(ref_div(a, b));
         op_q.push_back({a, b});
         n_issued++;
      end
      @(posedge clk);
      #1;
      if (!rn) begin
         exp_q.delete();
         op_q.delete();
      end
   endtask

   task automatic idle();
      drive(1'b1, 1'b0, '0, '0, 1'b1);
   endtask

   function automatic logic [DW-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 16'd1;
         2:       return 16'hFFFF;
         3:       return DW'($urandom_range(0, 15));
         default: return DW'($urandom_range(0, 65535));
      endcase
   endfunction

   // ---------------- monitor ----------------
   // Records whether the last rising edge could have advanced the pipeline.
   always @(posedge clk) adv <= clk_en && rst_n;

   // Pops and compares each new result. It also checks that results hold while
   // stalled and that the outputs read 0 when nothing is valid.
   always @(negedge clk) begin
      logic [2*DW:0]   e;
      logic [2*DW-1:0] op;
      int unsigned     qa, ra, aa, ba;
      if (mon_on) begin
         if (dv_o) begin
            if (adv) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_result: got q=%0h r=%0h with no pending operation", q_o, r_o);
               end else begin
                  e  = exp_q.pop_front();
                  op = op_q.pop_front();
                  chk("result", {q_o, r_o, dz_o}, e);
                  aa = op[2*DW-1:DW];
                  ba = op[DW-1:0];
                  qa = q_o;
                  ra = r_o;
                  if (ba != 0) chk("invariant", ((qa * ba + ra == aa) && (ra < ba)), 1'b1);
                  n_seen++;
               end
               last_out <= {q_o, r_o, dz_o};
            end else begin
               chk("stall_hold", {q_o, r_o, dz_o}, last_out);
            end
         end else begin
            chk("gated_zero", {q_o, r_o, dz_o}, '0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      rst_n  = 1'b0;
      clk_en = 1'b0;
      dv_i   = 1'b0;
      a_i    = '0;
      b_i    = '0;
      repeat (3) drive(1'b1, 1'b1, 16'd9, 16'd2, 1'b0);
      mon_on = 1'b1;
      chk("reset_valid", dv_o, 1'b0);
      chk("reset_outputs", {q_o, r_o, dz_o}, '0);

      // 100/7 single op: latency 3, single valid pulse
      drive(1'b1, 1'b1, 16'd100, 16'd7, 1'b1);
      chk("lat_edge1_valid", dv_o, 1'b0);
      idle();
      chk("lat_edge2_valid", dv_o, 1'b0);
      idle();
      chk("lat_edge3_valid", dv_o, 1'b1);
      chk("lat_edge3_data", {q_o, r_o, dz_o}, {16'd14, 16'd2, 1'b0});
      idle();
      chk("lat_after_valid", dv_o, 1'b0);
      chk("lat_after_data", {q_o, r_o, dz_o}, '0);

      // back-to-back operations
      drive(1'b1, 1'b1, 16'hFFFF, 16'd1, 1'b1);
      drive(1'b1, 1'b1, 16'd3, 16'd10, 1'b1);
      drive(1'b1, 1'b1, 16'h8000, 16'h0100, 1'b1);
      chk("b2b_0", {dv_o, q_o, r_o}, {1'b1, 16'hFFFF, 16'd0});
      idle();
      chk("b2b_1", {dv_o, q_o, r_o}, {1'b1, 16'd0, 16'd3});
      idle();
      chk("b2b_2", {dv_o, q_o, r_o}, {1'b1, 16'h0080, 16'd0});
      idle();
      idle();

      // divide by zero
      drive(1'b1, 1'b1, 16'd5, 16'd0, 1'b1);
      drive(1'b1, 1'b1, 16'd0, 16'd0, 1'b1);
      idle();
      chk("dz_5", {dv_o, q_o, r_o, dz_o}, {1'b1, 16'hFFFF, 16'd5, 1'b1});
      idle();
      chk("dz_0", {dv_o, q_o, r_o, dz_o}, {1'b1, 16'hFFFF, 16'd0, 1'b1});
      idle();
      idle();

      // clock-enable stall, including operands offered while stalled
      drive(1'b1, 1'b1, 16'd1000, 16'd33, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, pick(), pick(), 1'b1);
         chk("stall_no_valid", dv_o, 1'b0);
      end
      idle();
      chk("stall_edge2", dv_o, 1'b0);
      idle();
      chk("stall_result", {dv_o, q_o, r_o, dz_o}, {1'b1, 16'd30, 16'd10, 1'b0});
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      chk("stall_result_held", {dv_o, q_o, r_o}, {1'b1, 16'd30, 16'd10});
      idle();
      idle();

      // reset in the middle of operation
      drive(1'b1, 1'b1, 16'd10, 16'd3, 1'b1);
      drive(1'b1, 1'b1, 16'd20, 16'd3, 1'b1);
      drive(1'b1, 1'b1, 16'd30, 16'd3, 1'b0);
      chk("rst_flush_0", dv_o, 1'b0);
      drive(1'b1, 1'b1, 16'd50, 16'd8, 1'b1);
      chk("rst_flush_1", dv_o, 1'b0);
      idle();
      chk("rst_flush_2", dv_o, 1'b0);
      idle();
      chk("rst_after", {dv_o, q_o, r_o, dz_o}, {1'b1, 16'd6, 16'd2, 1'b0});
      repeat (PD) idle();

      // randomized operations with random enable and valid gaps
      n_issued = 0;
      n_seen   = 0;
      guard    = 0;
      while (n_issued < 10000 && guard < 40000) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, pick(), pick(), 1'b1);
         guard++;
      end
      chk("random_issue_budget", n_issued, 10000);
      repeat (PD + 2) idle();
      chk("drain_empty", exp_q.size(), 0);
      chk("valid_count", n_seen, n_issued);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipelined_array_divider.md
Name: pipelined_array_divider

Overview:
- Unsigned N-bit restoring array divider; the inverse of the team's pipelined array multiplier.
- Same pipeline-partitioning scheme, clock-enable and valid semantics, so the two blocks can be swapped or paired in the arithmetic unit.
- The quotient is resolved MSB-first, QUOTIENT_PER_STAGE bits per stage, across PIPELINE_DEPTH combinational stages separated by PIPELINE_DEPTH-1 register boundaries.

Parameters:
DATA_WIDTH, 16, operand/quotient/remainder width; must be a power of 2.
PIPELINE_DEPTH, 4, number of combinational stages; 2..DATA_WIDTH, must divide DATA_WIDTH.
QUOTIENT_PER_STAGE (localparam), DATA_WIDTH/PIPELINE_DEPTH, quotient bits resolved per stage.

Ports:
clk_i  input  1  clock, all state on rising edge
rst_n_i  input  1  synchronous active-low reset
clk_en_i  input  1  pipeline advance enable; low = every register holds
dividend_i  input  DATA_WIDTH  unsigned dividend
divisor_i  input  DATA_WIDTH  unsigned divisor
data_valid_i  input  1  operands valid this cycle
quotient_o  output  DATA_WIDTH  floor(dividend/divisor)
remainder_o  output  DATA_WIDTH  dividend mod divisor
divide_by_zero_o  output  1  divisor was 0 for the result on the outputs
data_valid_o  output  1  outputs valid

Behaviour:
- Reset: synchronous, active-low (sampled on rising clk_i while rst_n_i=0); clears every pipeline register, valid bit and quotient shift register to 0; dominates clk_en_i.
- Reset outputs: data_valid_o=0; quotient_o, remainder_o and divide_by_zero_o are 0.
- Output gating: quotient_o, remainder_o and divide_by_zero_o are forced to 0 whenever data_valid_o=0, so the invalid-output value is always defined.
- Stage k (k=0..PIPELINE_DEPTH-1) contents: partial remainder (DATA_WIDTH+1 bits), the unconsumed dividend bits, the divisor, and the quotient bits produced so far.
- Stage k datapath, repeated QUOTIENT_PER_STAGE times, combinationally:
  - shift the partial remainder left 1 and bring in the next dividend MSB;
  - trial-subtract the divisor with a DATA_WIDTH+1 bit subtractor;
  - if no borrow, keep the difference and set the quotient bit to 1; otherwise restore the remainder and set the quotient bit to 0.
- Stage 0 takes dividend_i/divisor_i directly with partial remainder 0.
- Registers sit after stages 0..PIPELINE_DEPTH-2. The final stage drives the outputs combinationally from the last register.
- Latency: exactly PIPELINE_DEPTH-1 enabled clk_i edges from an accepted input to its result. With PIPELINE_DEPTH=4 that is 3 cycles.
- Throughput: one operation per enabled cycle. There is no ready/backpressure; results appear in issue order.
- data_valid travels in a shift chain in lockstep with the data. Bubbles (data_valid_i=0) propagate as data_valid_o=0.
- clk_en_i=0: all registers (data and valid) hold, and the outputs stay stable. An input presented while clk_en_i=0 is not captured.
- divisor=0: no special datapath. The restoring algorithm naturally gives quotient all-ones and remainder = dividend.
  - A zero-detect bit is computed in stage 0 and pipelined alongside the data; it drives divide_by_zero_o.
- dividend < divisor: quotient 0, remainder = dividend.
- divisor=1: quotient = dividend, remainder 0.
- Invariant for every valid result with divisor != 0: quotient*divisor + remainder == dividend, and remainder < divisor.
- Reset mid-operation: all in-flight operations are discarded, with no valid pulse for them. The first input after release emerges after the full latency.
- Data registers may omit reset only if the output gating still forces 0s; the valid chain must always reset.

Test Plan (DATA_WIDTH=16, PIPELINE_DEPTH=4, latency 3):
- 100/7, valid for 1 cycle -> 3 cycles later data_valid_o=1, quotient_o=14, remainder_o=2, divide_by_zero_o=0; next cycle data_valid_o=0 and outputs 0.
- 0xFFFF/1, then 3/10, then 0x8000/0x0100 back-to-back -> consecutive valid results (0xFFFF,0), (0,3), (0x0080,0) in order.
- 5/0 -> quotient_o=0xFFFF, remainder_o=5, divide_by_zero_o=1; a following 0/0 gives 0xFFFF, 0, 1.
- Issue 1000/33, then hold clk_en_i=0 for 4 cycles after the first edge -> no output changes while stalled; result (30,10) appears after 3 enabled edges total.
- Issue 3 operations, assert rst_n_i=0 for 1 cycle after the 2nd edge -> data_valid_o stays 0 for all of them; a new 50/8 after release gives (6,2) exactly 3 cycles later.
- 10,000 random operands including 0, 1 and 0xFFFF with random clk_en_i and valid gaps -> every result matches the reference model and the invariant; valid count equals issued count.
